// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - completion request and CDB broadcast bundle for cdb_arbiter
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int SRC_W   = 2
) ();
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [SRC_W-1:0]         cdb_src;

    // master: the execution units plus the wakeup consumer
    modport master (
        output req_valid, req_tag,
        input  req_ready, cdb_valid, cdb_tag, cdb_src
    );

    modport slave (
        input  req_valid, req_tag,
        output req_ready, cdb_valid, cdb_tag, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin Common Data Bus arbiter with one holding slot per unit
// Optional conflict counter built only when CDB_CONFLICT_CNT_EN is defined.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int SRC_W   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    cdb_arbiter_if.slave        bus,
    output logic                busy,
    output logic [15:0]         conflict_cnt
);
    logic [NUM_REQ-1:0] hold_v;
    logic [TAG_W-1:0]   hold_tag [NUM_REQ];
    logic [SRC_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant_any;
    logic [SRC_W-1:0]   scan_idx;
    logic [NUM_REQ-1:0] accept;

    // Scan from rr_ptr upward; index arithmetic wraps because NUM_REQ is a power of two.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = rr_ptr + SRC_W'(k);
            if (!grant_any && hold_v[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_idx       = scan_idx;
                grant_any       = 1'b1;
            end
        end
    end

    // A slot being granted this cycle frees up in time to take the next tag.
    assign bus.req_ready = {NUM_REQ{!flush}} & (~hold_v | grant);
    assign accept        = bus.req_valid & bus.req_ready;
    assign busy          = |hold_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_v <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_tag[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush) begin
                    hold_v[i] <= 1'b0;
                end else if (accept[i]) begin
                    hold_v[i]   <= 1'b1;
                    hold_tag[i] <= bus.req_tag[i*TAG_W +: TAG_W];
                end else if (grant[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.cdb_valid <= 1'b0;
            bus.cdb_tag   <= '0;
            bus.cdb_src   <= '0;
            rr_ptr        <= '0;
        end else if (flush) begin
            bus.cdb_valid <= 1'b0;
            bus.cdb_tag   <= '0;
            bus.cdb_src   <= '0;
            rr_ptr        <= '0;
        end else if (grant_any) begin
            bus.cdb_valid <= 1'b1;
            bus.cdb_tag   <= hold_tag[grant_idx];
            bus.cdb_src   <= grant_idx;
            rr_ptr        <= grant_idx + SRC_W'(1);
        end else begin
            bus.cdb_valid <= 1'b0;
            bus.cdb_tag   <= '0;
            bus.cdb_src   <= '0;
        end
    end

`ifdef CDB_CONFLICT_CNT_EN
    logic        multi_pending;
    logic [15:0] conflict_q;

    // Clearing the lowest set bit leaves something only if two or more slots are pending.
    assign multi_pending = |(hold_v & (hold_v - NUM_REQ'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_q <= '0;
        end else if (multi_pending && conflict_q != 16'hFFFF) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
`ifdef CDB_CONFLICT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [5:0] tag;
        logic [1:0] src;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        busy;
    logic [15:0] conflict_cnt;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    cdb_arbiter_if #(.NUM_REQ(4), .TAG_W(6), .SRC_W(2)) bus ();

    cdb_arbiter #(.NUM_REQ(4), .TAG_W(6), .SRC_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .bus          (bus),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [5:0] tag, input logic [1:0] src, input int c);
        exp_t e;
        e.tag = tag;
        e.src = src;
        e.cyc = c;
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        bus.req_valid = '0;
        bus.req_tag   = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_tag !== 6'd0 || bus.cdb_src !== 2'd0) begin
            errors++;
            $display("FAIL reset_cdb got v=%b tag=%0d src=%0d exp 0/0/0", bus.cdb_valid, bus.cdb_tag, bus.cdb_src);
        end
        checks++;
        if (busy !== 1'b0 || conflict_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b cnt=%0d exp 0/0", busy, conflict_cnt);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 4'hF) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1111", bus.req_ready);
        end
    endtask

    task automatic drain_check(input string name);
        repeat (6) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending exp 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.req_valid = 4'b0001;
        bus.req_tag   = {18'd0, 6'd9};
        sb.push_back(mk(6'd9, 2'd0, cyc + 2));
        @(negedge clk);
        bus.req_valid = '0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_on got %b exp 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_off got %b exp 0", busy);
        end
        @(negedge clk);
        checks++;
        if (bus.cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_one_cycle got v=%b exp 0", bus.cdb_valid);
        end
        drain_check("single");
    endtask

    task automatic test_four_way();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_tag   = {6'd13, 6'd12, 6'd11, 6'd10};
        for (int i = 0; i < 4; i++) sb.push_back(mk(6'(10 + i), 2'(i), cyc + 2 + i));
        @(negedge clk);
        bus.req_valid = '0;
        drain_check("four_way");
        checks++;
        if (conflict_cnt !== (CNT_EN ? 16'd3 : 16'd0)) begin
            errors++;
            $display("FAIL four_way_conflict got %0d exp %0d", conflict_cnt, CNT_EN ? 3 : 0);
        end
    endtask

    task automatic test_rotation();
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.req_tag   = {6'd0, 6'd20, 12'd0};
        sb.push_back(mk(6'd20, 2'd2, cyc + 2));
        @(negedge clk);
        bus.req_valid = 4'b1010;
        bus.req_tag   = {6'd23, 6'd0, 6'd21, 6'd0};
        sb.push_back(mk(6'd23, 2'd3, cyc + 2));
        sb.push_back(mk(6'd21, 2'd1, cyc + 3));
        @(negedge clk);
        bus.req_valid = '0;
        drain_check("rotation");
        checks++;
        if (conflict_cnt !== (CNT_EN ? 16'd4 : 16'd0)) begin
            errors++;
            $display("FAIL rotation_conflict got %0d exp %0d", conflict_cnt, CNT_EN ? 4 : 0);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.req_valid = 4'b0010;
            bus.req_tag   = {12'd0, 6'(k + 1), 6'd0};
            sb.push_back(mk(6'(k + 1), 2'd1, cyc + 2));
            #1;
            checks++;
            if (bus.req_ready[1] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready k=%0d got %b exp 1", k, bus.req_ready[1]);
            end
        end
        @(negedge clk);
        bus.req_valid = '0;
        drain_check("b2b");
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.req_valid = 4'b1011;
        bus.req_tag   = {6'd33, 6'd0, 6'd31, 6'd30};
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.req_tag   = {6'd0, 6'd44, 12'd0};
        flush = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_ready got ready=%b busy=%b exp 0000/1", bus.req_ready, busy);
        end
        @(negedge clk);
        flush = 1'b0;
        bus.req_valid = '0;
        checks++;
        if (bus.cdb_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear got v=%b busy=%b exp 0/0", bus.cdb_valid, busy);
        end
        drain_check("flush");
        checks++;
        if (conflict_cnt !== (CNT_EN ? 16'd5 : 16'd0)) begin
            errors++;
            $display("FAIL flush_conflict got %0d exp %0d", conflict_cnt, CNT_EN ? 5 : 0);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.req_valid = 4'b1111;
        bus.req_tag   = {6'd53, 6'd52, 6'd51, 6'd50};
        sb.push_back(mk(6'd50, 2'd0, cyc + 2));
        sb.push_back(mk(6'd51, 2'd1, cyc + 3));
        @(negedge clk);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (conflict_cnt !== (CNT_EN ? 16'd7 : 16'd0)) begin
            errors++;
            $display("FAIL pre_reset_conflict got %0d exp %0d", conflict_cnt, CNT_EN ? 7 : 0);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.cdb_valid !== 1'b0 || busy !== 1'b0 || conflict_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b busy=%b cnt=%0d exp 0/0/0", bus.cdb_valid, busy, conflict_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pre_reset_bcast got %0d pending exp 0", sb.size());
        end
        sb.delete();
        // identical tags from units 1 and 3, expected in order from rr_ptr=0
        @(negedge clk);
        bus.req_valid = 4'b1010;
        bus.req_tag   = {6'd7, 6'd0, 6'd7, 6'd0};
        sb.push_back(mk(6'd7, 2'd1, cyc + 2));
        sb.push_back(mk(6'd7, 2'd3, cyc + 3));
        @(negedge clk);
        bus.req_valid = '0;
        drain_check("post_reset");
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.req_valid = '0;
        bus.req_tag   = '0;
        fork
            forever begin
                @(negedge clk);
                if (!reset && bus.cdb_valid === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_bcast got tag=%0d src=%0d cyc=%0d exp none", bus.cdb_tag, bus.cdb_src, cyc);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (bus.cdb_tag !== e.tag || bus.cdb_src !== e.src || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL bcast got tag=%0d src=%0d cyc=%0d exp tag=%0d src=%0d cyc=%0d",
                                     bus.cdb_tag, bus.cdb_src, cyc, e.tag, e.src, e.cyc);
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_single();
        test_four_way();
        test_rotation();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
